// File: rtl/msxbus_host_parser_if.sv
// rtl/msxbus_host_parser_if.sv - host byte port, bus-engine request and read-response signals
interface msxbus_host_parser_if;
    logic        CS;
    logic        PCLK;
    logic [7:0]  RDATA;
    logic        CMD_VALID;
    logic        CMD_READY;
    logic [1:0]  CMD_OP;
    logic [15:0] CMD_ADDR;
    logic [7:0]  CMD_WDATA;
    logic        RSP_VALID;
    logic [7:0]  RSP_DATA;
    logic [7:0]  HOST_DOUT;
    logic        HOST_DOE;
    logic        BUSY;
    logic        ERR;

    modport master (
        input  CS, PCLK, RDATA, CMD_READY, RSP_VALID, RSP_DATA,
        output CMD_VALID, CMD_OP, CMD_ADDR, CMD_WDATA, HOST_DOUT, HOST_DOE, BUSY, ERR
    );

    modport slave (
        output CS, PCLK, RDATA, CMD_READY, RSP_VALID, RSP_DATA,
        input  CMD_VALID, CMD_OP, CMD_ADDR, CMD_WDATA, HOST_DOUT, HOST_DOE, BUSY, ERR
    );
endinterface

// File: rtl/msxbus_host_parser.sv
// rtl/msxbus_host_parser.sv - host byte-frame parser feeding the MSX bus engine; MSXBUS_PARSER_BURST_EN enables in-frame bursts
module msxbus_host_parser #(
    parameter int SYNC_STAGES = 2
) (
    input  logic CLK,
    input  logic RST,
    msxbus_host_parser_if.master bus
);

    typedef enum logic [3:0] {
        IDLE, OPC, ADL, ADH, DAT, ISSUE, WRSP, HOLD, ERRS
    } state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] cs_sync;
    logic [SYNC_STAGES-1:0] pclk_sync;
    logic                   cs_prev;
    logic                   pclk_prev;
    logic                   cmd_valid;
    logic [1:0]             cmd_op;
    logic [15:0]            cmd_addr;
    logic [7:0]             cmd_wdata;
    logic [7:0]             host_dout;
    logic                   host_doe;
    logic                   err;
    logic                   abort_q;

    logic cs_s, pclk_s, byte_ev, frame_start, frame_end;

    assign cs_s        = cs_sync[SYNC_STAGES-1];
    assign pclk_s      = pclk_sync[SYNC_STAGES-1];
    assign byte_ev     = pclk_s & ~pclk_prev;
    assign frame_start = cs_prev & ~cs_s;
    assign frame_end   = ~cs_prev & cs_s;

    // CS resets to the deselected level so reset release never looks like a frame start
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cs_sync   <= '1;
            pclk_sync <= '0;
            cs_prev   <= 1'b1;
            pclk_prev <= 1'b0;
        end else begin
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], bus.CS};
            pclk_sync <= {pclk_sync[SYNC_STAGES-2:0], bus.PCLK};
            cs_prev   <= cs_s;
            pclk_prev <= pclk_s;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            cmd_valid <= 1'b0;
            cmd_op    <= 2'b00;
            cmd_addr  <= 16'h0000;
            cmd_wdata <= 8'h00;
            host_dout <= 8'h00;
            host_doe  <= 1'b0;
            err       <= 1'b0;
            abort_q   <= 1'b0;
        end else if (frame_end && state != IDLE && state != ISSUE) begin
            state    <= IDLE;
            host_doe <= 1'b0;
        end else begin
            case (state)
                IDLE: if (frame_start) begin
                    state    <= OPC;
                    err      <= 1'b0;
                    host_doe <= 1'b0;
                end
                OPC: if (byte_ev) begin
                    if (bus.RDATA[7:2] != 6'd0) begin
                        state <= ERRS;
                        err   <= 1'b1;
                    end else begin
                        cmd_op <= bus.RDATA[1:0];
                        state  <= ADL;
                    end
                end
                ADL: if (byte_ev) begin
                    cmd_addr[7:0] <= bus.RDATA;
                    state         <= ADH;
                end
                ADH: if (byte_ev) begin
                    cmd_addr[15:8] <= bus.RDATA;
                    if (cmd_op[0]) begin
                        state <= DAT;
                    end else begin
                        state     <= ISSUE;
                        cmd_valid <= 1'b1;
                    end
                end
                DAT: if (byte_ev) begin
                    cmd_wdata <= bus.RDATA;
                    state     <= ISSUE;
                    cmd_valid <= 1'b1;
                end
                // A frame end here must not drop an offered request; remember it until accepted
                ISSUE: begin
                    if (frame_end) begin
                        abort_q  <= 1'b1;
                        host_doe <= 1'b0;
                    end
                    if (bus.CMD_READY) begin
                        cmd_valid <= 1'b0;
                        abort_q   <= 1'b0;
                        if (abort_q || frame_end)
                            state <= IDLE;
                        else if (cmd_op[0])
                            state <= HOLD;
                        else
                            state <= WRSP;
                    end
                end
                WRSP: if (bus.RSP_VALID) begin
                    host_dout <= bus.RSP_DATA;
                    host_doe  <= 1'b1;
                    state     <= HOLD;
                end
`ifdef MSXBUS_PARSER_BURST_EN
                HOLD: if (byte_ev) begin
                    if (cmd_op[0])
                        cmd_wdata <= bus.RDATA;
                    cmd_addr  <= cmd_addr + 16'd1;
                    state     <= ISSUE;
                    cmd_valid <= 1'b1;
                end
`else
                HOLD: ;
`endif
                ERRS: ;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.CMD_VALID = cmd_valid;
    assign bus.CMD_OP    = cmd_op;
    assign bus.CMD_ADDR  = cmd_addr;
    assign bus.CMD_WDATA = cmd_wdata;
    assign bus.HOST_DOUT = host_dout;
    assign bus.HOST_DOE  = host_doe;
    assign bus.BUSY      = (state != IDLE);
    assign bus.ERR       = err;

endmodule

// File: doc/msxbus_host_parser.md
# msxbus_host_parser

- Host-side front end that sits directly upstream of the MSX bus cycle engine.
- Samples the host's parallel byte port (CS frame select, PCLK byte strobe, RDATA byte) into the CLK domain.
- Decodes the command frame: opcode, address low, address high, optional write data.
- Hands one complete bus request to the engine over a valid/ready handshake, then returns read data to the host.

## Interface
Parameters:
- SYNC_STAGES, 2: synchronizer depth for CS and PCLK (legal 2..3).

Ports:
- CLK  in  1  system clock (50 MHz).
- RST  in  1  asynchronous, active-high reset.
- CS  in  1  host frame select, active low, asynchronous to CLK.
- PCLK  in  1  host byte strobe, asynchronous; a byte is valid on its rising edge.
- RDATA  in  8  host byte; host holds it stable from ≥1 CLK before to ≥SYNC_STAGES+2 CLK after PCLK rise.
- CMD_VALID  out  1  request to bus engine.
- CMD_READY  in  1  engine accepts the request.
- CMD_OP  out  2  request type: 00 mem read, 01 mem write, 10 io read, 11 io write.
- CMD_ADDR  out  16  bus address.
- CMD_WDATA  out  8  write data.
- RSP_VALID  in  1  one-cycle pulse from engine: read data valid.
- RSP_DATA  in  8  read data.
- HOST_DOUT  out  8  read data toward host.
- HOST_DOE  out  1  host data drive enable.
- BUSY  out  1  high in every state except IDLE.
- ERR  out  1  sticky bad-opcode flag, cleared at the next frame start.

## Operation
- CS and PCLK each pass through SYNC_STAGES flops. A byte event fires on the first CLK where synced PCLK is 1 and was 0 on the previous CLK. RDATA is captured on that same cycle.
- Frame start is synced CS falling. Frame end is synced CS rising, which aborts to IDLE from any state, with one exception:
  - If CMD_VALID is high when CS rises, CMD_VALID, CMD_OP, CMD_ADDR and CMD_WDATA hold until CMD_READY, then the FSM goes to IDLE. No response wait follows.
- States: IDLE, OPC, ADL, ADH, DAT, ISSUE, WRSP, HOLD, ERRS.
  - IDLE→OPC on frame start. ERR clears here and HOST_DOE drops.
  - OPC, on a byte event:
    - RDATA[7:2]≠0: go to ERRS and set ERR.
    - Otherwise: latch RDATA[1:0] into CMD_OP and go to ADL.
  - ADL, on a byte event: latch CMD_ADDR[7:0], go to ADH.
  - ADH, on a byte event: latch CMD_ADDR[15:8]. Write ops (OP[0]=1) go to DAT; reads go to ISSUE.
  - DAT, on a byte event: latch CMD_WDATA, go to ISSUE.
  - ISSUE: CMD_VALID=1. On CMD_READY, reads go to WRSP and writes go to HOLD.
  - WRSP: on RSP_VALID, latch RSP_DATA into HOST_DOUT, set HOST_DOE=1, go to HOLD.
  - HOLD: waits for frame end; byte events are ignored (see Configuration).
  - ERRS: ignores everything until frame end.
- Byte events while in ISSUE or WRSP are dropped.
- Reset values: CMD_VALID=0, CMD_OP=0, CMD_ADDR=0x0000, CMD_WDATA=0x00, HOST_DOUT=0x00, HOST_DOE=0, BUSY=0, ERR=0, state IDLE.
- RST mid-operation drops CMD_VALID immediately, even if not yet accepted. The engine must tolerate this.

## Timing
- Byte capture: SYNC_STAGES+1 CLK after the PCLK rising edge (3 CLK at default).
- CMD_VALID: asserts the CLK after the final frame byte is captured. It is registered and deasserts the CLK after CMD_READY is sampled high.
- If CMD_READY is already high when CMD_VALID rises, the handshake completes in one cycle.
- HOST_DOUT/HOST_DOE: update the CLK after the RSP_VALID pulse.
- HOST_DOE falls SYNC_STAGES+1 CLK after CS rises.
- Minimum host byte period: 2·(SYNC_STAGES+1) CLK.

## Configuration
- MSXBUS_PARSER_BURST_EN defined: HOLD accepts further transfers within the same frame.
  - Writes: each byte event in HOLD latches CMD_WDATA, increments CMD_ADDR by 1 and goes to ISSUE.
  - Reads: each byte event in HOLD (byte value ignored) increments CMD_ADDR and goes to ISSUE. HOST_DOE stays 1 with the previous data until the new RSP_VALID.
  - CMD_ADDR wraps 0xFFFF→0x0000.
- Macro not defined: byte events in HOLD are ignored; exactly one bus request per frame.

## Test plan
- Mem read: CS low; bytes 0x00, 0x00, 0x40. Required: CMD_VALID with OP=00, ADDR=0x4000. Hold CMD_READY low 5 cycles, then pulse it; RSP_DATA=0x5A. Required: HOST_DOUT=0x5A, HOST_DOE=1 until CS high.
- IO write: bytes 0x03, 0x98, 0x00, 0xC3. Required: OP=11, ADDR=0x0098, WDATA=0xC3; no HOST_DOE.
- Bad opcode: byte 0x84. Required: ERR=1, no CMD_VALID for the rest of the frame; the next CS fall clears ERR.
- Abort: CS rises after ADL byte 0x12. Required: return to IDLE, BUSY=0, no request. Also CS rise while CMD_VALID is pending: the request holds until CMD_READY, then IDLE.
- Reset: RST pulses while in ISSUE. Required: CMD_VALID drops immediately and all outputs return to reset values.
- With MSXBUS_PARSER_BURST_EN: write frame 0x01, 0xFF, 0xFF, 0x11, 0x22. Required: two writes, to 0xFFFF (0x11) then 0x0000 (0x22). Without the macro: one write only.
